// File: rtl/mem_port_arbiter.sv
// Shares one single-port word-addressed RAM between the instruction-fetch
// port and the load/store data port. IDLE grants at most one command per
// cycle. RD_WAIT returns the registered RAM read data to the port that owns
// the read.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WORDS    = 4096,
  parameter int unsigned DATA_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // RAM side
  output logic [31:0] ram_address,
  output logic [3:0]  ram_byteenable,
  output logic        ram_write,
  output logic        ram_read,
  output logic [31:0] ram_writedata,
  input  logic [31:0] ram_readdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  state_t        state_q, state_d;
  port_t         last_grant_q, last_grant_d;
  port_t         owner_q, owner_d;
  logic [DW-1:0] i_hold_q, i_hold_d;
  logic [DW-1:0] d_hold_q, d_hold_d;

  logic [AW-1:0] i_word;
  logic [AW-1:0] d_word;
  logic          d_range_err;
  logic          d_align_err;
  logic          d_bad;
  logic          grant_i;
  logic          grant_d;
  logic          unused_addr_lsb;

  // Byte to word address. Fetches wrap modulo the RAM depth; data accesses
  // past the end are rejected instead.
  assign i_word          = AW'({2'b00, i_addr[31:2]} % AW'(ADDR_WORDS));
  assign d_word          = {2'b00, d_addr[31:2]};
  assign d_range_err     = d_word >= AW'(ADDR_WORDS);
  assign d_align_err     = (d_addr[1:0] != 2'b00) && (d_be == 4'hF);
  assign d_bad           = d_range_err || d_align_err;
  assign unused_addr_lsb = ^i_addr[1:0];

  // Winner selection: a lone requester wins; a tie goes to data when it has
  // fixed priority, else to the port that did not win last time.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (i_req && d_req) begin
        if (DATA_PRIORITY != 0) begin
          grant_d = 1'b1;
        end else if (last_grant_q == PORT_D) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Next-state, RAM command and port responses.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    i_hold_d       = i_hold_q;
    d_hold_d       = d_hold_q;
    i_ack          = 1'b0;
    d_ack          = 1'b0;
    d_err          = 1'b0;
    i_rvalid       = 1'b0;
    d_rvalid       = 1'b0;
    i_rdata        = i_hold_q;
    d_rdata        = d_hold_q;
    ram_address    = '0;
    ram_byteenable = 4'h0;
    ram_write      = 1'b0;
    ram_read       = 1'b0;
    ram_writedata  = '0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          i_ack          = 1'b1;
          last_grant_d   = PORT_I;
          ram_address    = i_word;
          ram_byteenable = 4'hF;
          ram_read       = 1'b1;
          owner_d        = PORT_I;
          state_d        = RD_WAIT;
        end else if (grant_d) begin
          d_ack        = 1'b1;
          last_grant_d = PORT_D;
          if (d_bad) begin
            d_err = 1'b1;
          end else begin
            ram_address    = d_word;
            ram_byteenable = d_be;
            ram_writedata  = d_wdata;
            if (d_we) begin
              ram_write = 1'b1;
            end else begin
              ram_read = 1'b1;
              owner_d  = PORT_D;
              state_d  = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        if (owner_q == PORT_I) begin
          i_rvalid = 1'b1;
          i_rdata  = ram_readdata;
          i_hold_d = ram_readdata;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = ram_readdata;
          d_hold_d = ram_readdata;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, arbitration history and read-data hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
      owner_q      <= PORT_I;
      i_hold_q     <= '0;
      d_hold_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      i_hold_q     <= i_hold_d;
      d_hold_q     <= d_hold_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance (0) and a data-priority
// instance (1) see the same stimulus. Each has its own RAM and its own
// behavioural model.
module tb_mem_port_arbiter;

  localparam int unsigned WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;

  logic        i_ack_w    [2];
  logic        i_rvalid_w [2];
  logic [31:0] i_rdata_w  [2];
  logic        d_ack_w    [2];
  logic        d_rvalid_w [2];
  logic [31:0] d_rdata_w  [2];
  logic        d_err_w    [2];
  logic [31:0] ram_addr_w [2];
  logic [3:0]  ram_be_w   [2];
  logic        ram_wr_w   [2];
  logic        ram_rd_w   [2];
  logic [31:0] ram_wd_w   [2];
  logic [31:0] ram_q_w    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int j);
    if (j == 4) return 32'hDEADBEEF;
    return (32'(j) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [31:0] mem [WORDS];

    mem_port_arbiter #(
      .ADDR_WORDS   (WORDS),
      .DATA_PRIORITY(g)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req         (i_req),
      .i_addr        (i_addr),
      .i_ack         (i_ack_w[g]),
      .i_rvalid      (i_rvalid_w[g]),
      .i_rdata       (i_rdata_w[g]),
      .d_req         (d_req),
      .d_we          (d_we),
      .d_addr        (d_addr),
      .d_be          (d_be),
      .d_wdata       (d_wdata),
      .d_ack         (d_ack_w[g]),
      .d_rvalid      (d_rvalid_w[g]),
      .d_rdata       (d_rdata_w[g]),
      .d_err         (d_err_w[g]),
      .ram_address   (ram_addr_w[g]),
      .ram_byteenable(ram_be_w[g]),
      .ram_write     (ram_wr_w[g]),
      .ram_read      (ram_rd_w[g]),
      .ram_writedata (ram_wd_w[g]),
      .ram_readdata  (ram_q_w[g])
    );

    initial begin
      for (int j = 0; j < int'(WORDS); j++) mem[j] = init_val(j);
      ram_q_w[g] = '0;
    end

    // Single-port RAM with a registered read.
    always @(posedge clk) begin
      if (ram_wr_w[g]) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_w[g][b]) mem[ram_addr_w[g][11:0]][8*b +: 8] <= ram_wd_w[g][8*b +: 8];
      end
      if (ram_rd_w[g]) ram_q_w[g] <= mem[ram_addr_w[g][11:0]];
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] model_mem [2][WORDS];
  bit          m_busy  [2];
  bit          m_owner [2];   // 0 = instruction, 1 = data
  bit          m_last  [2];   // 1 = data won last
  int          m_rdaddr[2];
  logic [31:0] m_ihold [2];
  logic [31:0] m_dhold [2];

  task automatic model_step(input int k);
    logic        e_iack, e_dack, e_derr, e_irv, e_drv, e_rd, e_wr;
    logic [31:0] e_addr, e_wd, e_ird, e_drd, v;
    logic [3:0]  e_be;
    bit          win_i, win_d;
    longint      dword;
    e_iack = 0; e_dack = 0; e_derr = 0; e_irv = 0; e_drv = 0; e_rd = 0; e_wr = 0;
    e_addr = 0; e_wd = 0; e_be = 0; win_i = 0; win_d = 0;
    if (!rst_n) begin
      m_busy[k] = 0; m_last[k] = 1; m_ihold[k] = 0; m_dhold[k] = 0;
    end
    e_ird = m_ihold[k];
    e_drd = m_dhold[k];
    if (rst_n && m_busy[k]) begin
      v = model_mem[k][m_rdaddr[k]];
      if (m_owner[k] == 0) begin e_irv = 1; e_ird = v; m_ihold[k] = v; end
      else                 begin e_drv = 1; e_drd = v; m_dhold[k] = v; end
      m_busy[k] = 0;
    end else if (rst_n) begin
      if (i_req && d_req) begin
        if (k == 1) win_d = 1;
        else if (m_last[k]) win_i = 1;
        else win_d = 1;
      end else begin
        win_i = i_req;
        win_d = d_req;
      end
      if (win_i) begin
        e_iack = 1; e_rd = 1; e_be = 4'hF;
        e_addr = 32'((i_addr / 4) % WORDS);
        m_last[k] = 0; m_busy[k] = 1; m_owner[k] = 0; m_rdaddr[k] = int'(e_addr);
      end else if (win_d) begin
        e_dack = 1; m_last[k] = 1;
        dword = longint'(d_addr / 4);
        if (dword >= longint'(WORDS) || (d_addr % 4 != 0 && d_be == 4'hF)) begin
          e_derr = 1;
        end else begin
          e_addr = 32'(dword); e_be = d_be; e_wd = d_wdata;
          if (d_we) begin
            e_wr = 1;
            for (int b = 0; b < 4; b++)
              if (d_be[b]) model_mem[k][int'(dword)][8*b +: 8] = d_wdata[8*b +: 8];
          end else begin
            e_rd = 1; m_busy[k] = 1; m_owner[k] = 1; m_rdaddr[k] = int'(dword);
          end
        end
      end
    end
    chk("i_ack", k, 32'(i_ack_w[k]), 32'(e_iack));
    chk("d_ack", k, 32'(d_ack_w[k]), 32'(e_dack));
    chk("d_err", k, 32'(d_err_w[k]), 32'(e_derr));
    chk("i_rvalid", k, 32'(i_rvalid_w[k]), 32'(e_irv));
    chk("d_rvalid", k, 32'(d_rvalid_w[k]), 32'(e_drv));
    chk("ram_read", k, 32'(ram_rd_w[k]), 32'(e_rd));
    chk("ram_write", k, 32'(ram_wr_w[k]), 32'(e_wr));
    chk("i_rdata", k, i_rdata_w[k], e_ird);
    chk("d_rdata", k, d_rdata_w[k], e_drd);
    if (e_rd || e_wr) begin
      chk("ram_address", k, ram_addr_w[k], e_addr);
      chk("ram_byteenable", k, 32'(ram_be_w[k]), 32'(e_be));
    end
    if (e_wr) chk("ram_writedata", k, ram_wd_w[k], e_wd);
  endtask

  // Compare process: every falling edge, both instances.
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < int'(WORDS); j++) model_mem[k][j] = init_val(j);
      m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 1; m_rdaddr[k] = 0;
      m_ihold[k] = 0; m_dhold[k] = 0;
    end
    forever begin
      @(negedge clk);
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  bit gseq[$];
  int i1_acks, d1_acks;

  initial begin
    rst_n = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
    @(negedge clk);
    chk("rst_i_rdata", 0, i_rdata_w[0], 32'h0);
    chk("rst_ram_read", 0, 32'(ram_rd_w[0]), 32'h0);
    cyc(); cyc();
    rst_n = 1;
    cyc();

    // instruction fetch of word 4
    i_req = 1; i_addr = 32'h10;
    @(negedge clk);
    chk("lit_fetch_ack", 0, 32'(i_ack_w[0]), 32'h1);
    chk("lit_fetch_addr", 0, ram_addr_w[0], 32'h4);
    cyc(); i_req = 0;
    @(negedge clk);
    chk("lit_fetch_rvalid", 0, 32'(i_rvalid_w[0]), 32'h1);
    chk("lit_fetch_rdata", 0, i_rdata_w[0], 32'hDEADBEEF);
    cyc();

    // write then read back word 8
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678; d_be = 4'hF;
    @(negedge clk);
    chk("lit_wr_ack", 0, 32'(d_ack_w[0]), 32'h1);
    chk("lit_wr_strobe", 0, 32'(ram_wr_w[0]), 32'h1);
    cyc(); d_we = 0;
    @(negedge clk);
    chk("lit_rd_ack", 0, 32'(d_ack_w[0]), 32'h1);
    cyc(); d_req = 0;
    @(negedge clk);
    chk("lit_rd_data", 0, d_rdata_w[0], 32'h12345678);
    cyc();

    // both ports reading continuously
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80; d_be = 4'hF;
    i1_acks = 0; d1_acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (i_ack_w[0]) gseq.push_back(1'b0);
      if (d_ack_w[0]) gseq.push_back(1'b1);
      if (i_ack_w[1]) i1_acks++;
      if (d_ack_w[1]) d1_acks++;
      cyc();
    end
    i_req = 0; d_req = 0;
    chk("lit_rr_grants", 0, 32'(gseq.size()), 32'd4);
    if (gseq.size() == 4)
      chk("lit_rr_order", 0, {28'h0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'h5);
    chk("lit_prio_i_starved", 1, 32'(i1_acks), 32'd0);
    chk("lit_prio_d_grants", 1, 32'(d1_acks), 32'd4);
    cyc();

    // rejected data accesses
    d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'hBAD0BAD0; d_be = 4'hF;
    @(negedge clk);
    chk("lit_range_err", 0, 32'(d_err_w[0]), 32'h1);
    chk("lit_range_nowr", 0, 32'(ram_wr_w[0]), 32'h0);
    cyc(); d_addr = 32'h22;
    @(negedge clk);
    chk("lit_align_err", 0, 32'(d_err_w[0]), 32'h1);
    cyc(); d_be = 4'h3; d_wdata = 32'hAAAABBBB;
    @(negedge clk);
    chk("lit_half_noerr", 0, 32'(d_err_w[0]), 32'h0);
    chk("lit_half_addr", 0, ram_addr_w[0], 32'h8);
    cyc(); d_we = 0; d_addr = 32'h20; d_be = 4'hF;
    cyc(); d_req = 0;
    @(negedge clk);
    chk("lit_half_data", 0, d_rdata_w[0], 32'h1234BBBB);
    cyc();

    // last valid word, then wrapped fetch
    d_req = 1; d_we = 0; d_addr = 32'h3FFC;
    @(negedge clk);
    chk("lit_top_addr", 0, ram_addr_w[0], 32'd4095);
    cyc(); d_req = 0;
    cyc();
    i_req = 1; i_addr = 32'h4010;
    @(negedge clk);
    chk("lit_wrap_addr", 0, ram_addr_w[0], 32'h4);
    cyc(); i_req = 0;
    @(negedge clk);
    chk("lit_wrap_data", 0, i_rdata_w[0], 32'hDEADBEEF);
    cyc();

    // reset during RD_WAIT
    i_req = 1; i_addr = 32'h40;
    cyc(); i_req = 0; rst_n = 0;
    @(negedge clk);
    chk("lit_rst_rvalid", 0, 32'(i_rvalid_w[0]), 32'h0);
    chk("lit_rst_rdata", 0, i_rdata_w[0], 32'h0);
    cyc(); cyc(); rst_n = 1;
    @(negedge clk);
    chk("lit_post_rst_rvalid", 0, 32'(i_rvalid_w[0]), 32'h0);
    cyc();
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    @(negedge clk);
    chk("lit_tie_i", 0, 32'(i_ack_w[0]), 32'h1);
    chk("lit_tie_prio_d", 1, 32'(d_ack_w[1]), 32'h1);
    cyc(); i_req = 0; d_req = 0;
    cyc();

    // data write arriving during an instruction read wait
    i_req = 1; i_addr = 32'h10;
    cyc(); i_req = 0; d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D; d_be = 4'hF;
    @(negedge clk);
    chk("lit_wait_noack", 0, 32'(d_ack_w[0]), 32'h0);
    cyc();
    @(negedge clk);
    chk("lit_wait_ack", 0, 32'(d_ack_w[0]), 32'h1);
    cyc(); d_we = 0;
    cyc(); d_req = 0;
    @(negedge clk);
    chk("lit_wait_data", 0, d_rdata_w[0], 32'hCAFEF00D);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word-addressed CPU RAM between the instruction-fetch port and the load/store data port of the MIPS CPU.
- Arbitrates round-robin between the two ports. Converts byte addresses to word addresses and sequences the RAM's 1-cycle registered read.
- Returns read data to the winning requester with a valid pulse.
- Sits between the CPU core and the RAM instance in the CPU testbench/top.

Parameters:
ADDR_WORDS, 4096, RAM depth in 32-bit words; word addresses >= ADDR_WORDS are errors.
DATA_PRIORITY, 0, 0 = round-robin on contention; 1 = data port always wins.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_req  input  1  instruction read request; held until i_ack
i_addr  input  32  instruction byte address
i_ack  output  1  command accepted this cycle
i_rvalid  output  1  i_rdata valid this cycle
i_rdata  output  32  fetched word
d_req  input  1  data request; held until d_ack
d_we  input  1  1 = write, 0 = read
d_addr  input  32  data byte address
d_be  input  4  byte enables, passed to RAM
d_wdata  input  32  write data
d_ack  output  1  command accepted or rejected this cycle
d_rvalid  output  1  d_rdata valid this cycle
d_rdata  output  32  loaded word
d_err  output  1  pulses with d_ack when the access was rejected
ram_address  output  32  word address to RAM
ram_byteenable  output  4  to RAM
ram_write  output  1  to RAM
ram_read  output  1  to RAM
ram_writedata  output  32  to RAM
ram_readdata  input  32  from RAM; valid the cycle after ram_read is sampled

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All acks, rvalids, d_err and ram_read/ram_write are 0.
  - i_rdata and d_rdata are 0.
  - Round-robin pointer last_grant=DATA, so the instruction port wins the first tie.
  - Reset mid-read drops the pending read; no rvalid is produced.
- FSM states: IDLE, RD_WAIT.
- IDLE, winner selection (combinational):
  - Only one port requesting: that port wins.
  - Both requesting: DATA_PRIORITY=1 gives data; otherwise the port opposite last_grant wins.
  - The winner's ack pulses for 1 cycle. last_grant is updated on the clock edge.
- RAM command from the winner (combinational, same cycle as ack):
  - ram_address = {2'b00, addr[31:2]}; addr[1:0] ignored.
  - Instruction: ram_read=1, ram_byteenable=4'hF.
  - Data: ram_write=d_we, ram_read=~d_we, ram_byteenable=d_be, ram_writedata=d_wdata.
- Data error:
  - Condition: word address >= ADDR_WORDS, or d_addr[1:0]!=0 with d_be=4'hF.
  - Response: d_ack=1 and d_err=1; no RAM strobe; state stays IDLE.
  - An instruction address out of range wraps modulo ADDR_WORDS (no error path).
- Writes complete in 1 cycle; state stays IDLE. Throughput is 1 write/cycle.
- Read: IDLE -> RD_WAIT on an accepted read; the read owner is recorded.
- RD_WAIT:
  - The owner's rvalid is 1 and its rdata = ram_readdata. The same value is latched into the owner's rdata hold register.
  - rdata holds its value until the next read by the same port.
  - No new command is accepted and both acks are 0.
  - Next state is IDLE.
  - Read latency is ack + 1 cycle; throughput is 1 read per 2 cycles.
- Request protocol:
  - A request dropped before ack has no effect.
  - Request inputs are sampled only in IDLE.
  - The non-winning port stays pending with its ack at 0.
- ram_read and ram_write are never both 1. Acks are never both 1.

Test Plan:
- Reset then i_req=1, i_addr=0x0000_0010 with RAM[4]=0xDEADBEEF -> i_ack in cycle 0, ram_address=4, ram_read=1; i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 1.
- d_req write, d_addr=0x20, d_wdata=0x12345678, d_be=F, then a data read of 0x20 -> write ack in 1 cycle; read returns 0x12345678 two cycles after the write ack.
- i_req and d_req held continuously (both reads), DATA_PRIORITY=0 -> grants alternate I,D,I,D; each rvalid goes only to its owner. With DATA_PRIORITY=1 -> data is always granted and instruction is starved.
- d_addr=0x0000_4000 (word 4096) or d_addr=0x22 with be=F -> d_ack=1, d_err=1, no ram strobe, RAM contents unchanged.
- Assert rst_n=0 during RD_WAIT -> outputs 0 immediately, no rvalid after release; the next tie goes to the instruction port.
- d_req write arriving during RD_WAIT of an instruction read -> d_ack is withheld until IDLE, then issued the following cycle.
